// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential instruction prefetcher that acts as the producer
// side of the instruction-queue FIFO. It issues in-order fetch requests,
// writes each response together with its PC straight into the FIFO, holds
// back requests whenever the FIFO could not absorb their responses, and on a
// redirect clears the queue and discards responses to requests made before it.
module fetch_prefetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 8,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             redirect_valid,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc,
    output logic                             imem_req_valid,
    output logic [ADDR_WIDTH-1:0]            imem_req_addr,
    input  logic                             imem_req_ready,
    input  logic                             imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            imem_rsp_data,
    output logic                             fifo_wr_cs,
    output logic                             fifo_wr_en,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_data_in,
    input  logic                             fifo_full,
    input  logic                             fifo_rd_pop,
    output logic                             fifo_flush,
    output logic                             overflow_err
);

    // Counter widths sized to hold their maximum values; SUM_W holds occ+outstanding.
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ((OUT_W > OCC_W) ? OUT_W : OCC_W) + 1;

    localparam logic [OUT_W-1:0]      OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]      OUT_ONE    = OUT_W'(1);
    localparam logic [OCC_W-1:0]      OCC_ONE    = OCC_W'(1);
    // The FIFO flags full one entry early, so only FIFO_DEPTH-1 slots are usable.
    localparam logic [SUM_W-1:0]      CREDITS    = SUM_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      outstanding_next;
    logic [OUT_W-1:0]      drop_cnt;
    logic [OUT_W-1:0]      drop_next;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_next;
    logic [SUM_W-1:0]      credits_used;
    logic                  req_fire;
    logic                  rsp_live;
    logic                  rsp_stale;
    logic                  wr_fire;
    logic                  pop_counted;

    // Instructions are word aligned; the low two redirect bits are forced to zero.
    assign redirect_base = redirect_pc & ALIGN_MASK;

    // Every accepted request reserves a FIFO slot until its response is popped.
    assign credits_used = SUM_W'(occ) + SUM_W'(outstanding);

    // Issue only in RUN, never in a redirect cycle, and only with a guaranteed slot.
    assign imem_req_valid = fetch_en
                         && (state == ST_RUN)
                         && !redirect_valid
                         && (outstanding < OUT_MAX)
                         && (credits_used < CREDITS);
    assign imem_req_addr  = req_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses to pre-redirect requests, or arriving with a redirect, are dropped.
    assign rsp_live  = fetch_en && imem_rsp_valid;
    assign rsp_stale = (drop_cnt != '0) || redirect_valid;
    assign wr_fire   = rsp_live && !rsp_stale;

    // The FIFO write is combinational so a response lands in the queue the cycle it arrives.
    assign fifo_wr_en   = wr_fire;
    assign fifo_wr_cs   = wr_fire;
    assign fifo_data_in = wr_fire ? {rsp_pc, imem_rsp_data} : '0;

    // A pop against an empty mirror can only be a stale entry awaiting the flush.
    assign pop_counted = fifo_rd_pop && (occ != '0);

    // Next values for the credit counters, the drop counter and the RUN/FLUSH state.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        outstanding_next = outstanding;
        occ_next         = occ;
        drop_next        = drop_cnt;
        state_next       = state;

        case ({req_fire, rsp_live})
            2'b10:   outstanding_next = outstanding + OUT_ONE;
            2'b01:   outstanding_next = outstanding - OUT_ONE;
            default: outstanding_next = outstanding;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            occ_next  = '0;
            drop_next = outstanding_next;
        end else begin
            case ({wr_fire, pop_counted})
                2'b10:   occ_next = occ + OCC_ONE;
                2'b01:   occ_next = occ - OCC_ONE;
                default: occ_next = occ;
            endcase
            if (rsp_live && (drop_cnt != '0)) begin
                drop_next = drop_cnt - OUT_ONE;
            end
        end

        // FLUSH lasts exactly as long as stale responses remain to be discarded.
        state_next = (drop_next != '0) ? ST_FLUSH : ST_RUN;
    end

    // Control registers: FSM state, credit counters, flush pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state        <= ST_RUN;
            fetch_en     <= 1'b0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            occ          <= '0;
            fifo_flush   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_en    <= 1'b1;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            occ         <= occ_next;
            fifo_flush  <= redirect_valid;
            if (wr_fire && fifo_full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // PC registers: request and response streams advance independently and restart together on a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            req_pc <= redirect_base;
            rsp_pc <= redirect_base;
        end else begin
            if (req_fire) begin
                req_pc <= req_pc + PC_STEP;
            end
            if (wr_fire) begin
                rsp_pc <= rsp_pc + PC_STEP;
            end
        end
    end

endmodule
